// File: rtl/logic_pkg.sv
// ---------------------------------------------------------------------------
// logic_pkg
// Shared definitions for the pipelined Y86-64 logical unit.
//   op_e        : in_op encoding (AND, OR, XOR, ANDN = In1 & ~In2)
//   flags_t     : zero / sign flag pair stored with every result
//   calc_flags  : derives ZF/SF from a result of any width up to MAX_W
//   entry_bits  : packed width of one FIFO entry {result, tag, zf, sf}
// ---------------------------------------------------------------------------
package logic_pkg;

  // Widest operand the flag helper can take; results are zero-extended into it.
  localparam int unsigned MAX_W = 256;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_ANDN = 2'b11
  } op_e;

  typedef struct packed {
    logic zf;
    logic sf;
  } flags_t;

  // The sign bit sits at position width-1 of the real result, so it is picked
  // out with a mask instead of a fixed index into the zero-extended value.
  function automatic flags_t calc_flags(input logic [MAX_W-1:0] value,
                                        input int unsigned      width);
    flags_t           flags;
    logic [MAX_W-1:0] msb_mask;
    msb_mask = {{(MAX_W-1){1'b0}}, 1'b1} << (width - 1);
    flags.zf = (value == '0);
    flags.sf = |(value & msb_mask);
    return flags;
  endfunction

  // One FIFO entry is the result, its tag and the two stored flags.
  function automatic int unsigned entry_bits(input int unsigned width,
                                             input int unsigned tag_w);
    return width + tag_w + 2;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// ---------------------------------------------------------------------------
// result_fifo
// Generic DEPTH-entry FIFO of DATA_W-bit words with registered occupancy.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   push/wdata : write request and data (ignored while full)
//   pop        : read request (ignored while empty)
//   rdata      : word at the read pointer
//   empty      : no word stored
//   count      : number of stored words, 0..DEPTH
// Every storage word resets to RESET_VAL so the head reads as a defined idle
// value while empty.
// ---------------------------------------------------------------------------
module result_fifo #(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       DEPTH     = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next-state for storage, pointers and occupancy. DEPTH is a power of two,
  // so the pointers wrap by plain binary overflow. A simultaneous push and pop
  // moves both pointers and leaves the count alone.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Reset drops every stored word at once so nothing in flight survives it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= RESET_VAL;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe
// Flow-controlled logical unit for the Y86-64 execute stage. Each accepted
// operation is evaluated combinationally and queued with its tag and flags
// in a DEPTH-entry result FIFO; results leave in acceptance order.
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   : operation handshake (in_ready from registered state)
//   in_op               : 00 AND, 01 OR, 10 XOR, 11 ANDN (In1 & ~In2)
//   In1, In2, in_tag    : operands and opaque tag
//   out_valid/out_ready : result handshake
//   Out, out_tag        : head result and its tag
//   ZF, SF, Overflow    : head flags (Overflow is always 0 for logical ops)
//   ops_done            : 16-bit wrapping count of popped results
// ---------------------------------------------------------------------------
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic [TAG_W-1:0] out_tag,
  output logic             ZF,
  output logic             SF,
  output logic             Overflow,
  output logic [15:0]      ops_done
);

  localparam int unsigned ENTRY_W = entry_bits(WIDTH, TAG_W);
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag;
    logic             zf;
    logic             sf;
  } entry_t;

  // Idle head value: zero result and tag, and ZF set because zero is zero.
  localparam entry_t RESET_ENTRY = '{result: '0, tag: '0, zf: 1'b1, sf: 1'b0};

  logic [WIDTH-1:0] op_result;
  flags_t           op_flags;
  entry_t           new_entry;
  entry_t           head_entry;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             do_accept;
  logic             do_pop;
  logic [15:0]      ops_done_q, ops_done_d;

  // Operation decode and flag generation for the operation being offered.
  always_comb begin
    op_result = '0;
    case (op_e'(in_op))
      OP_AND:  op_result = In1 & In2;
      OP_OR:   op_result = In1 | In2;
      OP_XOR:  op_result = In1 ^ In2;
      OP_ANDN: op_result = In1 & ~In2;
      default: op_result = '0;
    endcase
    op_flags         = calc_flags(MAX_W'(op_result), WIDTH);
    new_entry.result = op_result;
    new_entry.tag    = in_tag;
    new_entry.zf     = op_flags.zf;
    new_entry.sf     = op_flags.sf;
  end

  // Both handshakes are derived from the registered FIFO occupancy, so
  // in_ready never depends combinationally on out_ready.
  assign in_ready  = (fifo_count != CNT_W'(DEPTH));
  assign out_valid = !fifo_empty;
  assign do_accept = in_valid && in_ready;
  assign do_pop    = out_valid && out_ready;

  result_fifo #(
    .DATA_W    (ENTRY_W),
    .DEPTH     (DEPTH),
    .RESET_VAL (RESET_ENTRY)
  ) u_result_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (do_accept),
    .wdata (new_entry),
    .pop   (do_pop),
    .rdata (head_entry),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign Out      = head_entry.result;
  assign out_tag  = head_entry.tag;
  assign ZF       = head_entry.zf;
  assign SF       = head_entry.sf;
  assign Overflow = 1'b0;

  // Completed-operation counter; bumps once per pop and wraps at 2^16.
  always_comb begin
    ops_done_d = ops_done_q + 16'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done_q <= '0;
    end else begin
      ops_done_q <= ops_done_d;
    end
  end

  assign ops_done = ops_done_q;

endmodule
